// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants and arbiter state encoding for the VGA frame path
package vga_pkg;
  localparam int VTOTAL = 521;
  localparam int VPULSE = 2;
  localparam int VBP = 29;
  localparam int VDISP = 480;
  localparam int VSCALE = 5;
  localparam int HTOTAL = 1600;
  localparam int HPULSE = 192;
  localparam int HBP = 96;
  localparam int HDISP = 1280;
  localparam int HFP = 32;
  localparam int AW = 14;
  localparam int DW = 3;
  localparam int VACT_FIRST = VPULSE + VBP;
  localparam int VACT_LAST = VPULSE + VBP + VDISP - 1;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_ACK = 1'b1} arb_state_t;
endpackage

// File: rtl/vga_vtiming.sv
// vga_vtiming: scanline counter producing VSYNC, vertical display window, VPIXEL row and frame start
module vga_vtiming
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_line_end,
  output logic       o_vsync,
  output logic [6:0] o_vpixel,
  output logic       o_vactive,
  output logic       o_frame_start
);
  logic [9:0] r_vline;
  logic [2:0] r_sub;
  logic [6:0] r_vpixel;
  logic       r_vsync;
  logic       r_frame_start;
  logic [9:0] w_vline_nxt;
  logic       w_wrap;
  logic       w_act_nxt;
  assign w_wrap = r_vline == 10'(VTOTAL - 1);
  assign w_vline_nxt = w_wrap ? 10'd0 : r_vline + 10'd1;
  assign w_act_nxt = w_vline_nxt >= 10'(VACT_FIRST) && w_vline_nxt <= 10'(VACT_LAST);
  assign o_vactive = r_vline >= 10'(VACT_FIRST) && r_vline <= 10'(VACT_LAST);
  assign o_vsync = r_vsync;
  assign o_vpixel = r_vpixel;
  assign o_frame_start = r_frame_start;
  // Line counter, VSYNC and the frame-start pulse all advance on the same line_end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_vline <= '0;
      r_vsync <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= i_line_end && w_wrap;
      if (i_line_end) begin
        r_vline <= w_vline_nxt;
        r_vsync <= w_vline_nxt >= 10'(VPULSE);
      end
    end
  // VPIXEL steps once per VSCALE active lines and sits at 0 outside the vertical window
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_sub <= '0;
      r_vpixel <= '0;
    end else if (i_line_end) begin
      if (!w_act_nxt || !o_vactive) begin
        r_sub <= '0;
        r_vpixel <= '0;
      end else if (r_sub == 3'(VSCALE - 1)) begin
        r_sub <= '0;
        r_vpixel <= r_vpixel + 7'd1;
      end else
        r_sub <= r_sub + 3'd1;
    end
endmodule

// File: rtl/vga_frame_ctrl.sv
// vga_frame_ctrl: vertical timing, display-priority frame-buffer arbiter and pixel output pipeline
module vga_frame_ctrl
  import vga_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          line_end,
  input  logic          hactive,
  input  logic [6:0]    HPIXEL,
  output logic          VGA_VSYNC,
  output logic [6:0]    VPIXEL,
  output logic          frame_start,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] VGA_RGB
);
  arb_state_t    r_state, w_state_nxt;
  logic [AW-1:0] r_mem_addr, w_addr_nxt;
  logic [DW-1:0] r_mem_wdata, w_wdata_nxt;
  logic          r_mem_we, w_we_nxt;
  logic          r_wr_ack, w_ack_nxt;
  logic [1:0]    r_dv;
  logic [DW-1:0] r_rgb;
  logic          w_vactive;
  logic [6:0]    w_vpixel;
  logic          w_disp_active;
  vga_vtiming u_vtiming (
    .clk          (clk),
    .reset        (reset),
    .i_line_end   (line_end),
    .o_vsync      (VGA_VSYNC),
    .o_vpixel     (w_vpixel),
    .o_vactive    (w_vactive),
    .o_frame_start(frame_start)
  );
  assign VPIXEL = w_vpixel;
  assign w_disp_active = hactive & w_vactive;
  assign mem_addr = r_mem_addr;
  assign mem_we = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign wr_ack = r_wr_ack;
  assign VGA_RGB = r_rgb;
  // Arbiter decisions: display fetch always owns the port; a host write only slips into a blank cycle
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt = w_disp_active ? {w_vpixel, HPIXEL} : r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_we_nxt = 1'b0;
    w_ack_nxt = r_wr_ack;
    if (r_state == ARB_IDLE && !w_disp_active && wr_req) begin
      w_state_nxt = ARB_ACK;
      w_addr_nxt = wr_addr;
      w_wdata_nxt = wr_data;
      w_we_nxt = 1'b1;
      w_ack_nxt = 1'b1;
    end else if (r_state == ARB_ACK && !wr_req) begin
      w_state_nxt = ARB_IDLE;
      w_ack_nxt = 1'b0;
    end
  end
  // Arbiter state and registered memory-port outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= ARB_IDLE;
      r_mem_addr <= '0;
      r_mem_wdata <= '0;
      r_mem_we <= 1'b0;
      r_wr_ack <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mem_addr <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_mem_we <= w_we_nxt;
      r_wr_ack <= w_ack_nxt;
    end
  // Display valid tracks the address stage and the read-data stage; VGA_RGB is the third stage
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_dv <= '0;
      r_rgb <= '0;
    end else begin
      r_dv <= {r_dv[0], w_disp_active};
      r_rgb <= r_dv[1] ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_vga_frame_ctrl.sv
// tb_vga_frame_ctrl: randomized self-checking bench against a line-count reference model
module tb_vga_frame_ctrl;
  import vga_pkg::*;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          line_end = 1'b0;
  logic          hactive = 1'b0;
  logic [6:0]    HPIXEL = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          VGA_VSYNC, frame_start, wr_ack, mem_we;
  logic [6:0]    VPIXEL;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, VGA_RGB;
  int n_checks = 0;
  int n_fail = 0;
  int line = 0;
  logic [AW+DW-1:0] wq[$];

  always #10 clk = ~clk;

  vga_frame_ctrl dut (
    .clk(clk), .reset(reset), .line_end(line_end), .hactive(hactive), .HPIXEL(HPIXEL),
    .VGA_VSYNC(VGA_VSYNC), .VPIXEL(VPIXEL), .frame_start(frame_start),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .VGA_RGB(VGA_RGB)
  );

  // Memory model: read data is the low bits of the address presented one clock earlier
  always @(posedge clk) mem_rdata <= mem_addr[DW-1:0];
  // Write monitor: one entry per cycle in which mem_we is seen high
  always @(posedge clk) if (mem_we) wq.push_back({mem_addr, mem_wdata});

  function automatic int exp_vpix(int l);
    return (l >= VPULSE + VBP && l < VPULSE + VBP + VDISP) ? (l - VPULSE - VBP) / VSCALE : 0;
  endfunction

  task automatic advance(int n);
    if (n > 0) begin
      line_end = 1'b1;
      repeat (n) @(negedge clk);
      line_end = 1'b0;
      line = (line + n) % VTOTAL;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({VGA_VSYNC, VPIXEL, frame_start, wr_ack, mem_we, mem_addr, mem_wdata, VGA_RGB} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs vsync=%b vpix=%0d fs=%b ack=%b we=%b addr=%h wdata=%0d rgb=%0d, all required 0",
               VGA_VSYNC, VPIXEL, frame_start, wr_ack, mem_we, mem_addr, mem_wdata, VGA_RGB);
    end
    @(negedge clk);
    reset = 1'b1;
    line = 0;
  endtask

  task automatic test_frame;
    int pulses = 0;
    int fs_cnt = 0;
    logic fs_exp;
    while (pulses < VTOTAL) begin
      line_end = $urandom_range(0, 3) != 0;
      @(negedge clk);
      fs_exp = line_end && line == VTOTAL - 1;
      if (line_end) begin
        line = (line + 1) % VTOTAL;
        pulses++;
      end
      n_checks++;
      if (VGA_VSYNC !== (line >= VPULSE)) begin
        n_fail++;
        $display("FAIL frame_vsync line=%0d got=%b exp=%b", line, VGA_VSYNC, line >= VPULSE);
      end
      n_checks++;
      if (VPIXEL !== 7'(exp_vpix(line))) begin
        n_fail++;
        $display("FAIL frame_vpixel line=%0d got=%0d exp=%0d", line, VPIXEL, exp_vpix(line));
      end
      n_checks++;
      if (frame_start !== fs_exp) begin
        n_fail++;
        $display("FAIL frame_start line=%0d got=%b exp=%b", line, frame_start, fs_exp);
      end
      if (frame_start === 1'b1) fs_cnt++;
    end
    line_end = 1'b0;
    n_checks++;
    if (fs_cnt != 1) begin
      n_fail++;
      $display("FAIL frame_start_count got=%0d exp=1", fs_cnt);
    end
    @(negedge clk);
    n_checks++;
    if ({VGA_VSYNC, VPIXEL, frame_start, mem_we} !== '0) begin
      n_fail++;
      $display("FAIL frame_wrapped vsync=%b vpix=%0d fs=%b we=%b exp all 0", VGA_VSYNC, VPIXEL, frame_start, mem_we);
    end
  endtask

  task automatic test_write_blank;
    logic [AW-1:0] a[4];
    logic [DW-1:0] d[4];
    wq.delete();
    hactive = 1'b0;
    wr_addr = 14'h1A05;
    wr_data = 3'b101;
    wr_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, wr_ack} !== {1'b1, 14'h1A05, 3'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL blank_write we=%b addr=%h wdata=%0d ack=%b exp we=1 addr=1a05 wdata=5 ack=1",
               mem_we, mem_addr, mem_wdata, wr_ack);
    end
    repeat ($urandom_range(2, 6)) begin
      @(negedge clk);
      n_checks++;
      if ({mem_we, wr_ack} !== 2'b01) begin
        n_fail++;
        $display("FAIL blank_hold we=%b ack=%b exp we=0 ack=1", mem_we, wr_ack);
      end
    end
    wr_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL blank_ack_fall got=%b exp=0", wr_ack);
    end
    n_checks++;
    if (wq.size() != 1 || wq[0] !== {14'h1A05, 3'd5}) begin
      n_fail++;
      $display("FAIL blank_single_we writes=%0d exp=1", wq.size());
    end
    wq.delete();
    for (int i = 0; i < 4; i++) begin
      a[i] = 14'($urandom);
      d[i] = 3'($urandom);
      wr_addr = a[i];
      wr_data = d[i];
      wr_req = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      wr_req = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (wq.size() != 4) begin
      n_fail++;
      $display("FAIL rand_write_count got=%0d exp=4", wq.size());
    end else
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wq[i] !== {a[i], d[i]}) begin
          n_fail++;
          $display("FAIL rand_write_%0d got=%h exp=%h", i, wq[i], {a[i], d[i]});
        end
      end
  endtask

  task automatic test_contend;
    logic [6:0]    h;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            target;
    target = VPULSE + VBP + $urandom_range(0, VDISP - 10);
    advance((target - line + VTOTAL) % VTOTAL);
    wq.delete();
    a = 14'($urandom);
    d = 3'($urandom);
    h = 7'($urandom);
    hactive = 1'b1;
    HPIXEL = h;
    wr_addr = a;
    wr_data = d;
    wr_req = 1'b1;
    for (int i = 0; i < $urandom_range(4, 12); i++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_we, wr_ack, mem_addr} !== {1'b0, 1'b0, 7'(exp_vpix(line)), h}) begin
        n_fail++;
        $display("FAIL contend_display we=%b ack=%b addr=%h exp we=0 ack=0 addr=%h",
                 mem_we, wr_ack, mem_addr, {7'(exp_vpix(line)), h});
      end
      h = h + 7'd1;
      HPIXEL = h;
    end
    hactive = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, wr_ack} !== {1'b1, a, d, 1'b1}) begin
      n_fail++;
      $display("FAIL contend_write we=%b addr=%h wdata=%0d ack=%b exp we=1 addr=%h wdata=%0d ack=1",
               mem_we, mem_addr, mem_wdata, wr_ack, a, d);
    end
    wr_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_ack !== 1'b0 || wq.size() != 1) begin
      n_fail++;
      $display("FAIL contend_done ack=%b writes=%0d exp ack=0 writes=1", wr_ack, wq.size());
    end
  endtask

  task automatic test_rgb;
    logic [DW-1:0] hist[$];
    for (int i = 0; i < 40; i++) begin
      hactive = $urandom_range(0, 3) != 0;
      HPIXEL = 7'($urandom);
      hist.push_back(hactive ? HPIXEL[DW-1:0] : '0);
      @(negedge clk);
      if (i >= 2) begin
        n_checks++;
        if (VGA_RGB !== hist[i-2]) begin
          n_fail++;
          $display("FAIL rgb_pipe step=%0d got=%0d exp=%0d", i, VGA_RGB, hist[i-2]);
        end
      end
    end
    hactive = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (VGA_RGB !== '0) begin
      n_fail++;
      $display("FAIL rgb_blank got=%0d exp=0", VGA_RGB);
    end
  endtask

  task automatic test_reset_in_ack;
    hactive = 1'b0;
    wr_addr = 14'($urandom);
    wr_data = 3'($urandom);
    wr_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wr_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_before_reset got=%b exp=1", wr_ack);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({wr_ack, mem_we, VGA_VSYNC, VPIXEL} !== '0) begin
      n_fail++;
      $display("FAIL reset_in_ack ack=%b we=%b vsync=%b vpix=%0d exp all 0", wr_ack, mem_we, VGA_VSYNC, VPIXEL);
    end
    wr_req = 1'b0;
    line = 0;
    @(negedge clk);
    reset = 1'b1;
    wq.delete();
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if ({mem_we, wr_ack} !== 2'b00) begin
        n_fail++;
        $display("FAIL post_reset_idle we=%b ack=%b exp 0 0", mem_we, wr_ack);
      end
    end
    n_checks++;
    if (wq.size() != 0) begin
      n_fail++;
      $display("FAIL post_reset_stray writes=%0d exp=0", wq.size());
    end
    wr_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mem_we, wr_ack, mem_addr} !== {1'b1, 1'b1, wr_addr}) begin
      n_fail++;
      $display("FAIL rerequest we=%b ack=%b addr=%h exp we=1 ack=1 addr=%h", mem_we, wr_ack, mem_addr, wr_addr);
    end
    wr_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_frame;
    test_write_blank;
    test_contend;
    test_rgb;
    test_reset_in_ack;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_frame_ctrl.md
Name: vga_frame_ctrl

Overview:
- Frame-level controller for the 640x480 VGA path at 50 MHz.
- Counts scanlines from the horizontal timing block's one-cycle end-of-line pulse and generates VGA_VSYNC and the 7-bit vertical pixel index (VPIXEL, 0..95).
- Arbitrates a single synchronous frame-buffer port between display fetch and a host write port; display always has priority.
- Drives the pixel colour output after the memory read latency.

Parameters:
- VTOTAL, 521, scanlines per frame
- VPULSE, 2, VSYNC pulse width in lines
- VBP, 29, back porch in lines
- VDISP, 480, active lines
- VSCALE, 5, scanlines per VPIXEL row
- AW, 14, frame-buffer address width ({VPIXEL, HPIXEL})
- DW, 3, pixel width (R, G, B)

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- line_end  in  1  one-cycle pulse on the last clock of each 1600-cycle scanline
- hactive  in  1  horizontal display window active (cycles 288..1567 of the line)
- HPIXEL  in  7  horizontal pixel index from horizontal timing
- VGA_VSYNC  out  1  vertical sync, active low
- VPIXEL  out  7  vertical pixel index 0..95
- frame_start  out  1  one-cycle pulse when the line counter wraps to 0
- wr_req  in  1  host write request; addr and data held stable while high
- wr_addr  in  AW  host write address
- wr_data  in  DW  host write data
- wr_ack  out  1  four-phase acknowledge
- mem_addr  out  AW  frame-buffer address (registered)
- mem_we  out  1  frame-buffer write enable (registered)
- mem_wdata  out  DW  frame-buffer write data (registered)
- mem_rdata  in  DW  frame-buffer read data, valid 1 clock after mem_addr
- VGA_RGB  out  DW  pixel colour, 0 outside the display window

Behaviour:
- Reset values (reset low, asynchronous): VLINE=0, VPIXEL=0, row sub-counter=0, arbiter state=IDLE. Outputs: VGA_VSYNC=0 (line 0 lies in the pulse), frame_start=0, wr_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, VGA_RGB=0, all pipeline valids=0.
- Reset mid-write: the write is aborted and not retried; the host must re-request.
- Line counter VLINE (10 bits):
  - Advances only on line_end.
  - At VTOTAL-1 with line_end: wraps to 0 and frame_start=1 for the following cycle.
  - line_end held high continuously advances one line per clock; this is legal and is used by the bench.
- VGA_VSYNC = 0 iff VLINE < VPULSE; registered together with VLINE.
- vactive = VLINE in [VPULSE+VBP, VPULSE+VBP+VDISP-1], i.e. [31, 510].
- VPIXEL:
  - Forced to 0 whenever vactive=0.
  - During vactive, the sub-counter counts line_end pulses 0..VSCALE-1; at VSCALE-1 it clears and VPIXEL increments.
  - After 480 lines VPIXEL=95; the following line leaves vactive and VPIXEL returns to 0. No other wrap.
- disp_active = hactive & vactive.
- Arbiter FSM, decided in cycle n, visible on the memory port in n+1:
  - IDLE:
    - disp_active=1: mem_addr<={VPIXEL,HPIXEL}, mem_we<=0.
    - else if wr_req=1: mem_addr<=wr_addr, mem_wdata<=wr_data, mem_we<=1, wr_ack<=1, go to ACK.
    - else: mem_we<=0.
  - ACK:
    - mem_we<=0, wr_ack held 1; display reads continue while disp_active.
    - When wr_req=0: wr_ack<=0, go to IDLE.
  - Simultaneous disp_active and wr_req: display wins; the write stalls with no loss or corruption.
  - Exactly one mem_we cycle per handshake, regardless of how long wr_req stays high.
- Display pipeline:
  - disp_active is delayed 3 stages.
  - VGA_RGB <= mem_rdata if delay-2 valid, else 0.
  - VGA_RGB is therefore registered and reflects the HPIXEL/VPIXEL of 3 clocks earlier.

Decomposition:
- Shared package vga_pkg:
  - Timing constants VTOTAL/VPULSE/VBP/VDISP/VSCALE.
  - Horizontal constants 1600/192/96/1280/32.
  - AW and DW.
  - Arbiter state encoding (IDLE=0, ACK=1).
- One natural sub-module, vga_vtiming: VLINE, VGA_VSYNC, vactive, VPIXEL and frame_start.
- Arbiter and RGB pipeline stay in the top module.

Test Plan:
- Reset, then 521 line_end pulses -> VGA_VSYNC low for lines 0-1 only; one frame_start pulse after the 521st pulse; VLINE back to 0.
- Lines 31..510 -> VPIXEL steps 0,0,0,0,0,1,... every 5 lines; reaches 95 at line 506; returns to 0 at line 511.
- Blanking (hactive=0), wr_req with wr_addr=0x1A05 and wr_data=3'b101 -> next clock mem_we=1, mem_addr=0x1A05, mem_wdata=5, wr_ack=1. wr_ack falls 1 clock after wr_req drops. Exactly one mem_we.
- wr_req raised during disp_active -> no mem_we until hactive falls; write then issues on the first blank cycle; mem_addr sequence {VPIXEL,HPIXEL} is uninterrupted during active video.
- Active video with mem_rdata driven equal to the low 3 bits of the previous cycle's mem_addr -> VGA_RGB equals the low 3 bits of the HPIXEL from 3 clocks earlier; VGA_RGB=0 in blanking.
- Reset asserted (driven low) during the ACK state -> wr_ack=0, mem_we=0, VGA_VSYNC=0 immediately. After release, the FSM is in IDLE and no stray write occurs.
